// File: rtl/fiber_pkg.sv
// Shared definitions for the fiber link: frame geometry, receiver states and
// the frame checksum used by the transmitter, the receiver and the bench.
package fiber_pkg;

    localparam int BIT_CLKS   = 10;
    localparam int VOLT_W     = 12;
    localparam int INFO_W     = 14;
    localparam int CHK_W      = 7;
    localparam int FRAME_BITS = 80;
    localparam int SHIFT_W    = VOLT_W + INFO_W + CHK_W;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // Nibble-wise sum of voltage and info fields; the largest value is 93, so
    // seven bits never overflow.
    function automatic logic [CHK_W-1:0] fiber_chk(
        input logic [VOLT_W-1:0] volt,
        input logic [INFO_W-1:0] info
    );
        logic [CHK_W-1:0] sum;
        sum = CHK_W'(volt[3:0]) + CHK_W'(volt[7:4]) + CHK_W'(volt[11:8])
            + CHK_W'(info[3:0]) + CHK_W'(info[7:4]) + CHK_W'(info[11:8])
            + CHK_W'(info[13:12]);
        return sum;
    endfunction

endpackage

// File: rtl/fiber_sync.sv
// Two-flop synchroniser for the raw fiber line plus a falling-edge detector.
// Flops reset to 1 so an idle-high line never looks like a start edge.
module fiber_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_s,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values of the synchroniser chain and the edge-history flop.
    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign line_s = sync_q;
    assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/fiber_rx.sv
// Fiber frame receiver: finds the start bit, samples 33 payload bits at
// mid-bit, checks stop bit and checksum, and holds the last good frame.
module fiber_rx #(
    parameter int BIT_CLKS     = fiber_pkg::BIT_CLKS,
    parameter int SAMPLE_PT    = 4,
    parameter int LINK_TIMEOUT = 3200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        COMM_R,
    output logic [11:0] udc_volt,
    output logic [11:0] err_info,
    output logic        modu_run,
    output logic        byp_ok,
    output logic        frame_valid,
    output logic        chk_err,
    output logic        frm_err,
    output logic        link_lost
);
    import fiber_pkg::*;

    localparam int CNT_W = $clog2(BIT_CLKS);
    localparam int TMR_W = $clog2(LINK_TIMEOUT + 1);

    logic line_s, fall;

    fiber_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (COMM_R),
        .line_s  (line_s),
        .fall    (fall)
    );

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         idx_q, idx_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [11:0]        volt_q, volt_d;
    logic [11:0]        err_q, err_d;
    logic               run_q, run_d;
    logic               byp_q, byp_d;
    logic               fv_q, fv_d;
    logic               ce_q, ce_d;
    logic               fe_q, fe_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               lost_q, lost_d;

    logic               sample_hit;
    logic [VOLT_W-1:0]  rx_volt;
    logic [INFO_W-1:0]  rx_info;
    logic [CHK_W-1:0]   rx_chk;

    // Frame FSM: bit-cell counter runs freely outside IDLE, so every sample
    // lands SAMPLE_PT clocks into its cell relative to the start edge.
    always_comb begin
        sample_hit = (cnt_q == CNT_W'(SAMPLE_PT));
        rx_volt    = shift_q[VOLT_W-1:0];
        rx_info    = shift_q[VOLT_W+INFO_W-1:VOLT_W];
        rx_chk     = shift_q[SHIFT_W-1:VOLT_W+INFO_W];
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_W'(BIT_CLKS - 1)) ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        shift_d    = shift_q;
        volt_d     = volt_q;
        err_d      = err_q;
        run_d      = run_q;
        byp_d      = byp_q;
        fv_d       = 1'b0;
        ce_d       = 1'b0;
        fe_d       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (sample_hit) begin
                    if (!line_s) begin
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_hit) begin
                    shift_d = {line_s, shift_q[SHIFT_W-1:1]};
                    if (idx_q == 6'(SHIFT_W - 1)) state_d = STOP;
                    else idx_d = idx_q + 1'b1;
                end
            end
            STOP: begin
                if (sample_hit) begin
                    state_d = IDLE;
                    if (!line_s) begin
                        fe_d = 1'b1;
                    end else if (fiber_chk(rx_volt, rx_info) == rx_chk) begin
                        fv_d   = 1'b1;
                        volt_d = rx_volt;
                        err_d  = rx_info[11:0];
                        run_d  = rx_info[12];
                        byp_d  = rx_info[13];
                    end else begin
                        ce_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Link timer: restarts with each good frame, saturates at the timeout.
    always_comb begin
        if (fv_d) timer_d = '0;
        else if (timer_q == TMR_W'(LINK_TIMEOUT)) timer_d = timer_q;
        else timer_d = timer_q + 1'b1;
        lost_d = (timer_d == TMR_W'(LINK_TIMEOUT));
    end

    // State, datapath and output registers; reset leaves the link marked lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            volt_q  <= '0;
            err_q   <= '0;
            run_q   <= 1'b0;
            byp_q   <= 1'b0;
            fv_q    <= 1'b0;
            ce_q    <= 1'b0;
            fe_q    <= 1'b0;
            timer_q <= TMR_W'(LINK_TIMEOUT);
            lost_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            volt_q  <= volt_d;
            err_q   <= err_d;
            run_q   <= run_d;
            byp_q   <= byp_d;
            fv_q    <= fv_d;
            ce_q    <= ce_d;
            fe_q    <= fe_d;
            timer_q <= timer_d;
            lost_q  <= lost_d;
        end
    end

    assign udc_volt    = volt_q;
    assign err_info    = err_q;
    assign modu_run    = run_q;
    assign byp_ok      = byp_q;
    assign frame_valid = fv_q;
    assign chk_err     = ce_q;
    assign frm_err     = fe_q;
    assign link_lost   = lost_q;

endmodule

// File: tb/tb_fiber_rx.sv
// Bench for fiber_rx: table of whole frames with expected pulses/outputs,
// plus hand sequences for glitch, link loss and mid-frame reset.
module tb_fiber_rx;
    import fiber_pkg::*;

    localparam int BIT = 10;
    // Pin falling edge -> 3 clocks to registered edge, +345 to the pulse.
    localparam int LAT = 348;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        comm_r = 1'b1;
    logic [11:0] udc_volt, err_info;
    logic        modu_run, byp_ok, frame_valid, chk_err, frm_err, link_lost;

    fiber_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .COMM_R      (comm_r),
        .udc_volt    (udc_volt),
        .err_info    (err_info),
        .modu_run    (modu_run),
        .byp_ok      (byp_ok),
        .frame_valid (frame_valid),
        .chk_err     (chk_err),
        .frm_err     (frm_err),
        .link_lost   (link_lost)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse monitor, sampled on the falling edge.
    int          fv_cnt = 0, ce_cnt = 0, fe_cnt = 0, pulse_cyc = -1;
    int          excl_viol = 0, hold_viol = 0;
    logic        fv_prev = 1'b0, ce_prev = 1'b0, fe_prev = 1'b0;
    logic        ll_after_fv = 1'b1;
    logic        have_prev = 1'b0;
    logic [25:0] prev_out = '0;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt <= fv_cnt + 1;
        if (chk_err) ce_cnt <= ce_cnt + 1;
        if (frm_err) fe_cnt <= fe_cnt + 1;
        if (frame_valid || chk_err || frm_err) pulse_cyc <= cyc;
        if ((int'(frame_valid) + int'(chk_err) + int'(frm_err)) > 1 ||
            (frame_valid && fv_prev) || (chk_err && ce_prev) || (frm_err && fe_prev))
            excl_viol <= excl_viol + 1;
        if (rst_n && have_prev && !frame_valid &&
            ({udc_volt, err_info, modu_run, byp_ok} != prev_out))
            hold_viol <= hold_viol + 1;
        if (fv_prev) ll_after_fv <= link_lost;
        prev_out  <= {udc_volt, err_info, modu_run, byp_ok};
        have_prev <= rst_n;
        fv_prev   <= frame_valid;
        ce_prev   <= chk_err;
        fe_prev   <= frm_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drivers: every call starts and ends 1 time unit after a rising edge.
    task automatic hold_line(input logic v, input int n);
        comm_r = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full 80-slot frame: start, 33 data bits, stop, then idle high.
    task automatic send_frame(input logic [11:0] volt, input logic [13:0] info,
                              input logic [6:0] chk, input logic stop, output int fall_cyc);
        logic [32:0] bits;
        bits     = {chk, info, volt};
        fall_cyc = cyc;
        hold_line(1'b0, BIT);
        for (int i = 0; i < 33; i++) hold_line(bits[i], BIT);
        hold_line(stop, BIT);
        hold_line(1'b1, 45 * BIT);
    endtask

    typedef struct {
        logic [11:0] volt;
        logic [13:0] info;
        logic [6:0]  chk;
        logic        stop;
        logic [11:0] e_pulse;   // {valid, chk_err, frm_err} counts as hex digits
        logic [11:0] e_volt;
        logic [11:0] e_err;
        logic        e_run;
        logic        e_byp;
    } vec_t;

    vec_t vecs[8];

    task automatic check_frame(input string tag, input int fall, input vec_t v,
                               input int b_fv, input int b_ce, input int b_fe);
        check({tag, " pulses"}, 32'(((fv_cnt - b_fv) << 8) | ((ce_cnt - b_ce) << 4) | (fe_cnt - b_fe)),
              32'(v.e_pulse));
        check({tag, " latency"}, 32'(pulse_cyc - fall), LAT);
        check({tag, " udc_volt"}, 32'(udc_volt), 32'(v.e_volt));
        check({tag, " err_info"}, 32'(err_info), 32'(v.e_err));
        check({tag, " modu_run"}, 32'(modu_run), 32'(v.e_run));
        check({tag, " byp_ok"}, 32'(byp_ok), 32'(v.e_byp));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int fall, b_fv, b_ce, b_fe, k, last_fv;
        logic [32:0] pbits;

        vecs[0] = '{12'hABC, 14'h1123, 7'h28, 1'b1, 12'h100, 12'hABC, 12'h123, 1'b1, 1'b0};
        vecs[1] = '{12'hABC, 14'h1123, 7'h29, 1'b1, 12'h010, 12'hABC, 12'h123, 1'b1, 1'b0};
        vecs[2] = '{12'h555, 14'h2AAA, 7'h2F, 1'b0, 12'h001, 12'hABC, 12'h123, 1'b1, 1'b0};
        vecs[3] = '{12'h555, 14'h2AAA, 7'h2F, 1'b1, 12'h100, 12'h555, 12'hAAA, 1'b0, 1'b1};
        vecs[4] = '{12'hFFF, 14'h3FFF, 7'h5D, 1'b1, 12'h100, 12'hFFF, 12'hFFF, 1'b1, 1'b1};
        vecs[5] = '{12'h123, 14'h0F00, 7'h55, 1'b1, 12'h010, 12'hFFF, 12'hFFF, 1'b1, 1'b1};
        vecs[6] = '{12'h000, 14'h0000, 7'h00, 1'b1, 12'h100, 12'h000, 12'h000, 1'b0, 1'b0};
        vecs[7] = '{12'h123, 14'h0F00, 7'h15, 1'b1, 12'h100, 12'h123, 12'hF00, 1'b0, 1'b0};

        // Reset values.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst udc_volt", 32'(udc_volt), 0);
        check("rst err_info", 32'(err_info), 0);
        check("rst flags", 32'({modu_run, byp_ok, frame_valid, chk_err, frm_err}), 0);
        check("rst link_lost", 32'(link_lost), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold_line(1'b1, 20);

        // Back-to-back frames from the table.
        for (int i = 0; i < 8; i++) begin
            b_fv = fv_cnt; b_ce = ce_cnt; b_fe = fe_cnt;
            send_frame(vecs[i].volt, vecs[i].info, vecs[i].chk, vecs[i].stop, fall);
            check_frame($sformatf("vec%0d", i), fall, vecs[i], b_fv, b_ce, b_fe);
        end

        // Glitch: 3-clock low pulse is rejected at the start sample.
        b_fv = fv_cnt; b_ce = ce_cnt; b_fe = fe_cnt;
        k = cyc;
        hold_line(1'b0, 3);
        comm_r = 1'b1;
        while (cyc != k + 7) @(negedge clk);
        check("glitch in START", 32'(dut.state_q), 32'(START));
        @(negedge clk);
        check("glitch back IDLE", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk);
        #1;
        hold_line(1'b1, 60);
        check("glitch no pulse", 32'((fv_cnt - b_fv) + (ce_cnt - b_ce) + (fe_cnt - b_fe)), 0);

        // Link loss: five good frames, then silence.
        for (int i = 0; i < 5; i++) begin
            b_fv = fv_cnt;
            send_frame(12'hABC, 14'h1123, 7'h28, 1'b1, fall);
            check($sformatf("link frame%0d valid", i), 32'(fv_cnt - b_fv), 1);
            check($sformatf("link frame%0d link_lost", i), 32'(link_lost), 0);
        end
        last_fv = pulse_cyc;
        while (cyc != last_fv + 3199) @(negedge clk);
        check("link_lost before timeout", 32'(link_lost), 0);
        @(negedge clk);
        check("link_lost at timeout", 32'(link_lost), 1);
        @(posedge clk);
        #1;
        hold_line(1'b1, 5);
        b_fv = fv_cnt; b_ce = ce_cnt; b_fe = fe_cnt;
        send_frame(vecs[4].volt, vecs[4].info, vecs[4].chk, 1'b1, fall);
        check_frame("relink", fall, vecs[4], b_fv, b_ce, b_fe);
        check("relink link_lost cleared", 32'(ll_after_fv), 0);

        // Reset asserted during data bit 15.
        pbits = {7'h28, 14'h1123, 12'hABC};
        hold_line(1'b0, BIT);
        for (int i = 0; i < 15; i++) hold_line(pbits[i], BIT);
        hold_line(pbits[15], 5);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst udc_volt", 32'(udc_volt), 0);
        check("midrst err_info", 32'(err_info), 0);
        check("midrst flags", 32'({modu_run, byp_ok, frame_valid, chk_err, frm_err}), 0);
        check("midrst link_lost", 32'(link_lost), 1);
        check("midrst state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk);
        #1;
        hold_line(1'b1, 2);
        rst_n = 1'b1;
        hold_line(1'b1, 100);
        b_fv = fv_cnt; b_ce = ce_cnt; b_fe = fe_cnt;
        send_frame(vecs[0].volt, vecs[0].info, vecs[0].chk, 1'b1, fall);
        check_frame("post-reset", fall, vecs[0], b_fv, b_ce, b_fe);
        check("post-reset link_lost", 32'(link_lost), 0);

        // Whole-run properties.
        check("pulse width/exclusive", 32'(excl_viol), 0);
        check("outputs change only with frame_valid", 32'(hold_viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
